// File: rtl/lif_pkg.sv
// lif_pkg: shared widths, parameter-select encodings and scheduler state enum.
package lif_pkg;
    localparam int DATA_W = 16;
    localparam int CUR_W = 8;
    localparam logic [1:0] SEL_E_REST = 2'd0;
    localparam logic [1:0] SEL_E_TAU = 2'd1;
    localparam logic [1:0] SEL_V_TH = 2'd2;
    localparam logic [1:0] SEL_CLR_OVR = 2'd3;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;
endpackage

// File: rtl/lif_tag_pipe.sv
// lif_tag_pipe: DP_LAT-deep valid+index delay line tracking in-flight datapath work.
module lif_tag_pipe #(
    parameter int DP_LAT = 9,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);
    logic [DP_LAT-1:0] r_v;
    logic [IDX_W-1:0] r_idx [DP_LAT];
    always_ff @(posedge clk) begin
        r_v <= rst ? '0 : DP_LAT'({r_v, in_valid});
    end
    // Indices need no reset: they are only consumed alongside a set valid bit.
    always_ff @(posedge clk) begin
        r_idx[0] <= in_idx;
        for (int k = 1; k < DP_LAT; k++) r_idx[k] <= r_idx[k-1];
    end
    assign out_valid = r_v[DP_LAT-1];
    assign out_idx = r_idx[DP_LAT-1];
endmodule

// File: rtl/lif_neuron_scheduler.sv
// lif_neuron_scheduler: time-multiplexes N_NEURONS LIF neurons over one pipelined datapath.
// Define LIF_SCHED_SPIKE_CNT_EN to add the per-step spike_cnt output.
module lif_neuron_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS = 8,
    parameter int DP_LAT = 9,
    localparam int IDX_W = $clog2(N_NEURONS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              vm_we,
    input  logic [IDX_W-1:0]  vm_addr,
    input  logic [DATA_W-1:0] vm_data,
    input  logic              cur_we,
    input  logic [IDX_W-1:0]  cur_addr,
    input  logic [CUR_W-1:0]  cur_data,
    input  logic              step,
    output logic [DATA_W-1:0] e_rest,
    output logic [DATA_W-1:0] e_tau,
    output logic [DATA_W-1:0] v_th,
    output logic              dp_issue,
    output logic [DATA_W-1:0] dp_v,
    output logic [CUR_W-1:0]  dp_i,
    input  logic [DATA_W-1:0] dp_vout,
    input  logic              dp_spike,
    output logic              busy,
    output logic              step_done,
    output logic              overrun,
    output logic              spike_valid,
    output logic [IDX_W-1:0]  spike_idx
`ifdef LIF_SCHED_SPIKE_CNT_EN
    ,
    output logic [IDX_W:0]    spike_cnt
`endif
);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);
    state_t r_state, w_next;
    logic [IDX_W-1:0] r_idx;
    logic [DATA_W-1:0] r_vmem [N_NEURONS];
    logic [CUR_W-1:0] r_cur [N_NEURONS];
    logic [DATA_W-1:0] r_e_rest, r_e_tau, r_v_th;
    logic r_overrun;
    logic w_idle, w_issue, w_done, w_last, w_tail_v;
    logic [IDX_W-1:0] w_tail_idx;
    lif_tag_pipe #(.DP_LAT(DP_LAT), .IDX_W(IDX_W)) u_tag_pipe (
        .clk(clk),
        .rst(rst),
        .in_valid(w_issue),
        .in_idx(r_idx),
        .out_valid(w_tail_v),
        .out_idx(w_tail_idx)
    );
    assign w_last = w_tail_v && w_tail_idx == IDX_LAST;
    always_ff @(posedge clk) begin
        r_state <= rst ? ST_IDLE : w_next;
    end
    always_comb begin
        w_next = r_state;
        w_idle = 1'b0;
        w_issue = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idle = 1'b1;
                w_next = step ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: begin
                w_issue = 1'b1;
                w_next = (r_idx == IDX_LAST) ? ST_DRAIN : ST_ISSUE;
            end
            ST_DRAIN: w_next = w_last ? ST_DONE : ST_DRAIN;
            default: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
        endcase
    end
    // Host writes only land in IDLE, so they never collide with write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_e_rest <= '0;
            r_e_tau <= '0;
            r_v_th <= '0;
            r_overrun <= 1'b0;
            for (int k = 0; k < N_NEURONS; k++) begin
                r_vmem[k] <= '0;
                r_cur[k] <= '0;
            end
        end else begin
            r_idx <= w_issue ? r_idx + IDX_W'(1) : '0;
            if (w_idle && cfg_we && cfg_sel == SEL_E_REST) r_e_rest <= cfg_data;
            if (w_idle && cfg_we && cfg_sel == SEL_E_TAU) r_e_tau <= cfg_data;
            if (w_idle && cfg_we && cfg_sel == SEL_V_TH) r_v_th <= cfg_data;
            if (w_idle && cfg_we && cfg_sel == SEL_CLR_OVR) r_overrun <= 1'b0;
            else if (step && !w_idle) r_overrun <= 1'b1;
            if (w_idle && vm_we) r_vmem[vm_addr] <= vm_data;
            if (w_idle && cur_we) r_cur[cur_addr] <= cur_data;
            if (w_tail_v) r_vmem[w_tail_idx] <= dp_vout;
        end
    end
    // Every output is forced low while reset is held.
    assign e_rest = rst ? '0 : r_e_rest;
    assign e_tau = rst ? '0 : r_e_tau;
    assign v_th = rst ? '0 : r_v_th;
    assign dp_issue = !rst && w_issue;
    assign dp_v = dp_issue ? r_vmem[r_idx] : '0;
    assign dp_i = dp_issue ? r_cur[r_idx] : '0;
    assign busy = !rst && !w_idle;
    assign step_done = !rst && w_done;
    assign overrun = !rst && r_overrun;
    assign spike_valid = !rst && w_tail_v && dp_spike;
    assign spike_idx = spike_valid ? w_tail_idx : '0;
`ifdef LIF_SCHED_SPIKE_CNT_EN
    logic [IDX_W:0] r_spike_cnt;
    always_ff @(posedge clk) begin
        r_spike_cnt <= (rst || (w_idle && step)) ? '0 : r_spike_cnt + (IDX_W + 1)'(spike_valid);
    end
    assign spike_cnt = rst ? '0 : r_spike_cnt;
`endif
endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// tb_lif_neuron_scheduler: random and directed stimulus against a per-step reference model.
module tb_lif_neuron_scheduler;
    localparam int N = 8, L = 9, IW = 3, T = N + L + 1;
    logic clk = 0, rst = 1, cfg_we = 0, vm_we = 0, cur_we = 0, step = 0, dp_spike = 0;
    logic [1:0] cfg_sel = 0;
    logic [15:0] cfg_data = 0, vm_data = 0, dp_vout = 0;
    logic [IW-1:0] vm_addr = 0, cur_addr = 0;
    logic [7:0] cur_data = 0;
    logic [15:0] e_rest, e_tau, v_th, dp_v;
    logic [7:0] dp_i;
    logic dp_issue, busy, step_done, overrun, spike_valid;
    logic [IW-1:0] spike_idx;
`ifdef LIF_SCHED_SPIKE_CNT_EN
    logic [IW:0] spike_cnt;
`endif
    lif_neuron_scheduler #(.N_NEURONS(N), .DP_LAT(L)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .vm_we(vm_we), .vm_addr(vm_addr), .vm_data(vm_data),
        .cur_we(cur_we), .cur_addr(cur_addr), .cur_data(cur_data), .step(step),
        .e_rest(e_rest), .e_tau(e_tau), .v_th(v_th),
        .dp_issue(dp_issue), .dp_v(dp_v), .dp_i(dp_i), .dp_vout(dp_vout), .dp_spike(dp_spike),
        .busy(busy), .step_done(step_done), .overrun(overrun),
        .spike_valid(spike_valid), .spike_idx(spike_idx)
`ifdef LIF_SCHED_SPIKE_CNT_EN
        , .spike_cnt(spike_cnt)
`endif
    );
    always #5 clk = ~clk;

    logic [15:0] m_vm [N], m_snap_v [N], m_par [4];
    logic [7:0] m_cur [N], m_snap_i [N];
    logic m_ovr = 0;
    int m_s = -1, m_scnt = 0, cyc = 0, n_chk = 0, n_pass = 0, seen_spk = 0, seen_idx = 0;
    logic [16:0] resp [int];
    logic [15:0] dp_o;

    function automatic logic [15:0] dp_fn(logic [15:0] v, logic [7:0] i);
        return v + 16'(i) + 16'd1;
    endfunction
    function automatic bit exp_spike(int r);
        if (r < L + 1 || r > L + N) return 0;
        return dp_fn(m_snap_v[IW'(r - L - 1)], m_snap_i[IW'(r - L - 1)]) >= m_par[2];
    endfunction

    // Datapath stand-in: answers each issue exactly L cycles later, junk otherwise.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (dp_issue) begin
            dp_o = dp_fn(dp_v, dp_i);
            resp[cyc + L] = {dp_o >= m_par[2], dp_o};
        end
        if (resp.exists(cyc)) begin
            {dp_spike, dp_vout} = resp[cyc];
            resp.delete(cyc);
        end else begin
            dp_vout = 16'($urandom);
            dp_spike = 1'($urandom);
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    endtask

    task automatic check();
        int r = (m_s < 0) ? -1 : cyc - m_s;
        bit iss = !rst && r >= 1 && r <= N;
        bit spk = !rst && exp_spike(r);
        chk("busy", busy, !rst && r >= 1 && r <= T);
        chk("step_done", step_done, !rst && r == T);
        chk("overrun", overrun, !rst && m_ovr);
        chk("dp_issue", dp_issue, iss);
        chk("dp_v", dp_v, iss ? m_snap_v[IW'(r - 1)] : 16'h0);
        chk("dp_i", dp_i, iss ? m_snap_i[IW'(r - 1)] : 8'h0);
        chk("spike_valid", spike_valid, spk);
        chk("spike_idx", spike_idx, spk ? IW'(r - L - 1) : '0);
        chk("e_rest", e_rest, rst ? 16'h0 : m_par[0]);
        chk("e_tau", e_tau, rst ? 16'h0 : m_par[1]);
        chk("v_th", v_th, rst ? 16'h0 : m_par[2]);
`ifdef LIF_SCHED_SPIKE_CNT_EN
        chk("spike_cnt", spike_cnt, rst ? 0 : m_scnt);
`endif
        if (spike_valid) begin
            seen_spk++;
            seen_idx = seen_idx * 16 + int'(spike_idx);
        end
    endtask

    // Applies the inputs held during the current cycle to the model.
    task automatic model_apply();
        int r = (m_s < 0) ? -1 : cyc - m_s;
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_vm[k] = 0;
                m_cur[k] = 0;
            end
            for (int k = 0; k < 4; k++) m_par[k] = 0;
            m_ovr = 0;
            m_s = -1;
            m_scnt = 0;
            return;
        end
        if (exp_spike(r)) m_scnt++;
        if (r >= 1 && r <= T) begin
            if (step) m_ovr = 1;
            if (r == T) begin
                for (int k = 0; k < N; k++) m_vm[k] = dp_fn(m_snap_v[k], m_snap_i[k]);
                m_s = -1;
            end
        end else begin
            if (cfg_we && cfg_sel == 2'd3) m_ovr = 0;
            else if (cfg_we) m_par[cfg_sel] = cfg_data;
            if (vm_we) m_vm[vm_addr] = vm_data;
            if (cur_we) m_cur[cur_addr] = cur_data;
            if (step) begin
                m_s = cyc;
                m_snap_v = m_vm;
                m_snap_i = m_cur;
                m_scnt = 0;
            end
        end
    endtask

    task automatic tick();
        model_apply();
        @(negedge clk);
        check();
        step = 0;
        cfg_we = 0;
        vm_we = 0;
        cur_we = 0;
    endtask
    task automatic cfg(input logic [1:0] s, input logic [15:0] d);
        cfg_we = 1;
        cfg_sel = s;
        cfg_data = d;
        tick();
    endtask
    task automatic vmw(input logic [IW-1:0] a, input logic [15:0] d);
        vm_we = 1;
        vm_addr = a;
        vm_data = d;
        tick();
    endtask

    initial begin
        @(negedge clk);
        check();
        repeat (2) tick();
        rst = 0;
        tick();
        cfg(2'd0, 16'hC400);
        cfg(2'd1, 16'h018E);
        cfg(2'd2, 16'h3C00);
        for (int k = 0; k < N; k++)
            vmw(IW'(k), k == 3 ? 16'h3BFF : k == 6 ? 16'h4000 : 16'(k * 256));
        vm_we = 1;
        vm_addr = 2;
        vm_data = 16'h1234;
        step = 1;
        tick();
        seen_spk = 0;
        seen_idx = 0;
        for (int c = 1; c <= T + 1; c++) begin
            if (c == 5) step = 1;
            if (c == 7) begin
                cfg_we = 1;
                cfg_sel = 2'd2;
                cfg_data = 16'h0;
            end
            tick();
        end
        chk("spike_count", seen_spk, 2);
        chk("spike_order", seen_idx, 32'h36);
`ifdef LIF_SCHED_SPIKE_CNT_EN
        chk("spike_cnt_hold", spike_cnt, 2);
`endif
        cfg(2'd3, 16'h0);
        step = 1;
        tick();
        repeat (N + 3) tick();
        rst = 1;
        tick();
        rst = 0;
        tick();
        step = 1;
        tick();
        repeat (T + 1) tick();
        repeat (3000) begin
            rst = ($urandom_range(0, 199) == 0);
            step = ($urandom_range(0, 5) == 0);
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_sel = 2'($urandom);
            cfg_data = 16'($urandom);
            vm_we = ($urandom_range(0, 3) == 0);
            vm_addr = IW'($urandom);
            vm_data = 16'($urandom);
            cur_we = ($urandom_range(0, 3) == 0);
            cur_addr = IW'($urandom);
            cur_data = 8'($urandom);
            tick();
        end
        rst = 0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
